// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter
// Brief    : Two-requester arbiter/sequencer for a shared 32-bit barrel shifter.
//            Optional round-robin arbitration via `SHIFT_ARB_RR_EN.
// Revision : 1.0
// ============================================================================
module shifter_arbiter #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_0,
    input  logic          req_valid_1,
    output logic          req_ready_0,
    output logic          req_ready_1,
    input  logic [W-1:0]  req_data_0,
    input  logic [W-1:0]  req_data_1,
    input  logic [AW-1:0] req_amt_0,
    input  logic [AW-1:0] req_amt_1,
    input  logic [1:0]    req_op_0,
    input  logic [1:0]    req_op_1,
    output logic          resp_valid_0,
    output logic          resp_valid_1,
    input  logic          resp_ready_0,
    input  logic          resp_ready_1,
    output logic [W-1:0]  resp_data,
    output logic [W-1:0]  sh_in,
    output logic [5:0]    sh,
    output logic          sh_rotate,
    output logic          shift_LeftRight,
    output logic          rotate_LeftRight,
    input  logic [W-1:0]  sh_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_owner;
    logic [W-1:0]   r_data;
    logic [W-1:0]   r_resp_data;
    logic [4:0]     r_amt;
    logic [1:0]     r_op;
    logic           r_zero;

    logic           w_prio1;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_accept;
    logic           w_resp_fire;
    logic [W-1:0]   w_data;
    logic [AW-1:0]  w_amt;
    logic [1:0]     w_op;

`ifdef SHIFT_ARB_RR_EN
    // Pointer set means requester 1 wins a tie; it flips to the non-owner
    // whenever a response completes.
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_resp_fire) begin
            r_ptr <= ~r_owner;
        end
    end

    assign w_prio1 = r_ptr;
`else
    assign w_prio1 = 1'b0;
`endif

    assign w_grant0    = req_valid_0 & (~req_valid_1 | ~w_prio1);
    assign w_grant1    = req_valid_1 & (~req_valid_0 |  w_prio1);
    assign w_accept    = rst_n & (r_state == S_IDLE) & (w_grant0 | w_grant1);
    assign w_resp_fire = (r_state == S_RESP) & (r_owner ? resp_ready_1 : resp_ready_0);

    assign w_data = w_grant1 ? req_data_1 : req_data_0;
    assign w_amt  = w_grant1 ? req_amt_1  : req_amt_0;
    assign w_op   = w_grant1 ? req_op_1   : req_op_0;

    assign resp_valid_0 = (r_state == S_RESP) & ~r_owner;
    assign resp_valid_1 = (r_state == S_RESP) &  r_owner;
    assign resp_data    = r_resp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        req_ready_0      = 1'b0;
        req_ready_1      = 1'b0;
        sh_in            = '0;
        sh               = '0;
        sh_rotate        = 1'b0;
        shift_LeftRight  = 1'b0;
        rotate_LeftRight = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_0 = rst_n & w_grant0;
                req_ready_1 = rst_n & w_grant1;
                if (w_accept) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                sh_in            = r_data;
                sh               = {1'b0, r_amt};
                sh_rotate        = r_op[1];
                shift_LeftRight  = ~r_op[1] & ~r_op[0];
                rotate_LeftRight =  r_op[1] & ~r_op[0];
                w_next           = S_RESP;
            end
            S_RESP: begin
                if (w_resp_fire) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shifts of 32 or more flush the operand entirely; rotates just wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_data      <= '0;
            r_amt       <= '0;
            r_op        <= '0;
            r_zero      <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant1;
                r_data  <= w_data;
                r_amt   <= w_amt[4:0];
                r_op    <= w_op;
                r_zero  <= ~w_op[1] & (|w_amt[AW-1:5]);
            end
            if (r_state == S_EXEC) begin
                r_resp_data <= r_zero ? '0 : sh_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_arbiter
// Brief    : Directed self-checking bench for shifter_arbiter with a
//            behavioural barrel shifter on the shared shifter port.
// Revision : 1.0
// ============================================================================
module tb_shifter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [31:0] req_data_0, req_data_1;
    logic [5:0]  req_amt_0, req_amt_1;
    logic [1:0]  req_op_0, req_op_1;
    logic        resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
    logic [31:0] resp_data, sh_in, sh_out;
    logic [5:0]  sh;
    logic        sh_rotate, shift_LeftRight, rotate_LeftRight;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shifter_arbiter #(.W(32), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_data_0(req_data_0), .req_data_1(req_data_1),
        .req_amt_0(req_amt_0), .req_amt_1(req_amt_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_data(resp_data), .sh_in(sh_in), .sh(sh),
        .sh_rotate(sh_rotate), .shift_LeftRight(shift_LeftRight),
        .rotate_LeftRight(rotate_LeftRight), .sh_out(sh_out)
    );

    // Behavioural stand-in for the external combinational barrel shifter.
    logic [63:0] w_dbl, w_rol, w_ror;
    always_comb begin
        w_dbl = {sh_in, sh_in};
        w_rol = w_dbl << sh[4:0];
        w_ror = w_dbl >> sh[4:0];
        if (sh_rotate) sh_out = rotate_LeftRight ? w_rol[63:32] : w_ror[31:0];
        else           sh_out = shift_LeftRight ? (sh_in << sh[4:0]) : (sh_in >> sh[4:0]);
    end

    // Presents a request and waits (bounded) for its acceptance edge; returns
    // #1 after the accept edge, i.e. during EXEC.
    task automatic accept(input bit who, input logic [31:0] d, input logic [5:0] a,
                          input logic [1:0] op, output bit ok);
        ok = 1'b0;
        if (!who) begin req_valid_0 = 1; req_data_0 = d; req_amt_0 = a; req_op_0 = op; end
        else      begin req_valid_1 = 1; req_data_1 = d; req_amt_1 = a; req_op_1 = op; end
        #1;
        for (int i = 0; i < 10; i++) begin
            if ((!who && req_ready_0) || (who && req_ready_1)) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        if (!who) req_valid_0 = 0; else req_valid_1 = 0;
    endtask

    task automatic ack(input bit who);
        if (!who) resp_ready_0 = 1; else resp_ready_1 = 1;
        @(posedge clk); #1;
        resp_ready_0 = 0; resp_ready_1 = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, sh_rotate,
             shift_LeftRight, rotate_LeftRight} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0", {req_ready_0, req_ready_1,
                     resp_valid_0, resp_valid_1, sh_rotate, shift_LeftRight, rotate_LeftRight});
        else n_pass++;
        n_checks++;
        if ({resp_data, sh_in, sh} !== 70'b0)
            $display("FAIL reset_data: resp_data=%h sh_in=%h sh=%h want 0", resp_data, sh_in, sh);
        else n_pass++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_contention;
        bit exp_g [4];
        bit saw1;
        bit exp_saw1;
`ifdef SHIFT_ARB_RR_EN
        exp_g = '{0, 1, 0, 1}; exp_saw1 = 1;
`else
        exp_g = '{0, 0, 0, 0}; exp_saw1 = 0;
`endif
        saw1 = 0;
        req_data_0 = 32'h11; req_amt_0 = 0; req_op_0 = 2'b00;
        req_data_1 = 32'h22; req_amt_1 = 0; req_op_1 = 2'b00;
        req_valid_0 = 1; req_valid_1 = 1;
        #1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 10; i++) begin
                if (req_ready_0 || req_ready_1) break;
                @(posedge clk); #1;
            end
            if (req_ready_1) saw1 = 1;
            n_checks++;
            if ({req_ready_1, req_ready_0} !== (exp_g[t] ? 2'b10 : 2'b01))
                $display("FAIL grant%0d: ready{1,0}=%b want %b", t, {req_ready_1, req_ready_0},
                         exp_g[t] ? 2'b10 : 2'b01);
            else n_pass++;
            @(posedge clk); #1;
            @(posedge clk); #1;
            n_checks++;
            if ({resp_valid_1, resp_valid_0, resp_data} !==
                {(exp_g[t] ? 2'b10 : 2'b01), (exp_g[t] ? 32'h22 : 32'h11)})
                $display("FAIL grant%0d_resp: valid{1,0}=%b data=%h want owner %0d", t,
                         {resp_valid_1, resp_valid_0}, resp_data, exp_g[t]);
            else n_pass++;
            resp_ready_0 = 1; resp_ready_1 = 1;
            @(posedge clk); #1;
            resp_ready_0 = 0; resp_ready_1 = 0;
        end
        req_valid_0 = 0; req_valid_1 = 0;
        n_checks++;
        if (saw1 !== exp_saw1) $display("FAIL ready1_seen: got %b want %b", saw1, exp_saw1);
        else n_pass++;
    endtask

    task automatic test_sll;
        bit ok;
        accept(0, 32'hFFFF0000, 6'd4, 2'b00, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL sll_accept: ready_0 never high, want accept");
        else n_pass++;
        n_checks++;
        if ({sh_rotate, shift_LeftRight, rotate_LeftRight, sh, sh_in} !== {3'b010, 6'd4, 32'hFFFF0000})
            $display("FAIL sll_exec: rot=%b sl=%b rl=%b sh=%0d in=%h want 0 1 0 4 ffff0000",
                     sh_rotate, shift_LeftRight, rotate_LeftRight, sh, sh_in);
        else n_pass++;
        n_checks++;
        if ({req_ready_0, resp_valid_0} !== 2'b00)
            $display("FAIL sll_exec_hs: ready0=%b resp_valid0=%b want 0 0", req_ready_0, resp_valid_0);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({resp_valid_0, resp_valid_1, resp_data} !== {2'b10, 32'hFFF00000})
            $display("FAIL sll_resp: v0=%b v1=%b data=%h want 1 0 fff00000",
                     resp_valid_0, resp_valid_1, resp_data);
        else n_pass++;
        n_checks++;
        if ({sh_in, sh} !== 38'b0) $display("FAIL sll_resp_shport: sh_in=%h sh=%0d want 0", sh_in, sh);
        else n_pass++;
        ack(0);
        n_checks++;
        if (resp_valid_0 !== 1'b0) $display("FAIL sll_ack: resp_valid_0=%b want 0", resp_valid_0);
        else n_pass++;
    endtask

    task automatic test_ror;
        bit ok;
        accept(1, 32'hFFFF0000, 6'd8, 2'b11, ok);
        n_checks++;
        if ({ok, sh_rotate, shift_LeftRight, rotate_LeftRight, sh} !== {4'b1100, 6'd8})
            $display("FAIL ror_exec: ok=%b rot=%b sl=%b rl=%b sh=%0d want 1 1 0 0 8",
                     ok, sh_rotate, shift_LeftRight, rotate_LeftRight, sh);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({resp_valid_1, resp_valid_0, resp_data} !== {2'b10, 32'h00FFFF00})
            $display("FAIL ror_resp: v1=%b v0=%b data=%h want 1 0 00ffff00",
                     resp_valid_1, resp_valid_0, resp_data);
        else n_pass++;
        ack(1);
    endtask

    task automatic test_amount_norm;
        logic [31:0] t_d   [3] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFF0000};
        logic [5:0]  t_a   [3] = '{6'd40, 6'd32, 6'd40};
        logic [1:0]  t_op  [3] = '{2'b01, 2'b00, 2'b10};
        logic [5:0]  t_sh  [3] = '{6'd8, 6'd0, 6'd8};
        logic [31:0] t_res [3] = '{32'h0, 32'h0, 32'hFF0000FF};
        bit ok;
        for (int v = 0; v < 3; v++) begin
            accept(0, t_d[v], t_a[v], t_op[v], ok);
            n_checks++;
            if ({ok, sh} !== {1'b1, t_sh[v]})
                $display("FAIL norm%0d_sh: ok=%b sh=%0d want 1 %0d", v, ok, sh, t_sh[v]);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if ({resp_valid_0, resp_data} !== {1'b1, t_res[v]})
                $display("FAIL norm%0d_data: v0=%b data=%h want 1 %h", v, resp_valid_0, resp_data, t_res[v]);
            else n_pass++;
            ack(0);
        end
    endtask

    task automatic test_stall;
        bit ok;
        accept(0, 32'h12345678, 6'd4, 2'b00, ok);
        @(posedge clk); #1;
        req_data_1 = 32'h5; req_amt_1 = 0; req_op_1 = 2'b00; req_valid_1 = 1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({resp_valid_0, resp_data, req_ready_0, req_ready_1} !== {1'b1, 32'h23456780, 2'b00})
                $display("FAIL stall%0d: v0=%b data=%h rdy0=%b rdy1=%b want 1 23456780 0 0",
                         c, resp_valid_0, resp_data, req_ready_0, req_ready_1);
            else n_pass++;
            @(posedge clk); #1;
        end
        resp_ready_0 = 1;
        @(posedge clk); #1;
        resp_ready_0 = 0;
        n_checks++;
        if ({resp_valid_0, req_ready_1} !== 2'b01)
            $display("FAIL stall_release: v0=%b rdy1=%b want 0 1", resp_valid_0, req_ready_1);
        else n_pass++;
        req_valid_1 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        accept(1, 32'hA5A5A5A5, 6'd3, 2'b01, ok);
        rst_n = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, sh_rotate, shift_LeftRight,
             rotate_LeftRight, sh, sh_in, resp_data} !== 77'b0)
            $display("FAIL midrst_out: v0=%b v1=%b sh_in=%h sh=%0d data=%h want all 0",
                     resp_valid_0, resp_valid_1, sh_in, sh, resp_data);
        else n_pass++;
        rst_n = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({resp_valid_0, resp_valid_1} !== 2'b00)
            $display("FAIL midrst_noresp: v0=%b v1=%b want 0 0", resp_valid_0, resp_valid_1);
        else n_pass++;
        req_data_0 = 32'h0000000F; req_amt_0 = 6'd4; req_op_0 = 2'b11;
        req_data_1 = 32'h1;        req_amt_1 = 6'd1; req_op_1 = 2'b00;
        req_valid_0 = 1; req_valid_1 = 1;
        #1;
        n_checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10)
            $display("FAIL midrst_prio: rdy0=%b rdy1=%b want 1 0", req_ready_0, req_ready_1);
        else n_pass++;
        @(posedge clk); #1;
        req_valid_0 = 0; req_valid_1 = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({resp_valid_0, resp_valid_1, resp_data} !== {2'b10, 32'hF0000000})
            $display("FAIL midrst_next: v0=%b v1=%b data=%h want 1 0 f0000000",
                     resp_valid_0, resp_valid_1, resp_data);
        else n_pass++;
        ack(0);
    endtask

    initial begin
        rst_n = 0;
        req_valid_0 = 0; req_valid_1 = 0; resp_ready_0 = 0; resp_ready_1 = 0;
        req_data_0 = 0; req_data_1 = 0; req_amt_0 = 0; req_amt_1 = 0;
        req_op_0 = 0; req_op_1 = 0;
        test_reset();
        test_contention();
        test_sll();
        test_ror();
        test_amount_norm();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
